// File: rtl/sync_fifo_param_if.sv
// Handshake bundle between a single-clock producer/consumer and sync_fifo_param.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_param_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] wdata;
    logic                  winc;
    logic                  wfull;
    logic                  walmost_full;
    logic                  rinc;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rempty;
    logic                  ralmost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wdata, winc, rinc,
        input  wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );

    modport slave (
        input  wdata, winc, rinc,
        output wfull, walmost_full, rdata, rempty, ralmost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with registered status flags, occupancy count,
// sticky overflow/underflow and selectable standard or first-word-fall-through read.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned AFULL_THRESH  = 14,
    parameter int unsigned AEMPTY_THRESH = 2,
    parameter int unsigned FWFT          = 0
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_param_if.slave fifo_if
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    localparam logic [ADDR_WIDTH:0] DepthCnt  = CW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFullCnt  = CW'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEmptyCnt = CW'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] OneCnt    = CW'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  wfull_q, wfull_d;
    logic                  rempty_q, rempty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] head_word;
    logic                  wr_en, rd_en;

    assign wr_en     = fifo_if.winc && !wfull_q;
    assign rd_en     = fifo_if.rinc && !rempty_q;
    assign head_word = mem_q[rptr_q[ADDR_WIDTH-1:0]];

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rdata_d     = rdata_q;
        overflow_d  = overflow_q  | (fifo_if.winc && wfull_q);
        underflow_d = underflow_q | (fifo_if.rinc && rempty_q);

        if (wr_en) wptr_d = wptr_q + OneCnt;
        if (rd_en) begin
            rptr_d  = rptr_q + OneCnt;
            rdata_d = head_word;
        end

        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + OneCnt;
            2'b01:   count_d = count_q - OneCnt;
            default: count_d = count_q;
        endcase

        // Flags track the post-update count so they are valid right after the edge.
        wfull_d  = (count_d == DepthCnt);
        rempty_d = (count_d == '0);
        afull_d  = (count_d >= AFullCnt);
        aempty_d = (count_d <= AEmptyCnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wfull_q     <= 1'b0;
            rempty_q    <= 1'b1;
            afull_q     <= (AFULL_THRESH == 0);
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            wfull_q     <= wfull_d;
            rempty_q    <= rempty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rdata_q     <= rdata_d;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= fifo_if.wdata;
    end

    assign fifo_if.wfull         = wfull_q;
    assign fifo_if.walmost_full  = afull_q;
    assign fifo_if.rempty        = rempty_q;
    assign fifo_if.ralmost_empty = aempty_q;
    assign fifo_if.count         = count_q;
    assign fifo_if.overflow      = overflow_q;
    assign fifo_if.underflow     = underflow_q;
    // Fall-through mode presents the head entry directly, zeroed while empty.
    assign fifo_if.rdata = (FWFT != 0) ? (rempty_q ? '0 : head_word) : rdata_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-read and one fall-through instance.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if0 ();
    sync_fifo_param_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) if1 ();

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2),
                      .FWFT(0))
        u_dut0 (.clk(clk), .rst(rst), .fifo_if(if0.slave));

    sync_fifo_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2),
                      .FWFT(1))
        u_dut1 (.clk(clk), .rst(rst), .fifo_if(if1.slave));

    // One clock of stimulus on the standard instance; outputs sampled 1ns after the edge.
    task automatic cyc0(input logic w, input logic [7:0] d, input logic r);
        if0.winc = w; if0.wdata = d; if0.rinc = r;
        @(posedge clk); #1;
        if0.winc = 1'b0; if0.rinc = 1'b0;
    endtask

    task automatic cyc1(input logic w, input logic [7:0] d, input logic r);
        if1.winc = w; if1.wdata = d; if1.rinc = r;
        @(posedge clk); #1;
        if1.winc = 1'b0; if1.rinc = 1'b0;
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc0(1'b0, 8'h00, 1'b1);
        total_cnt++;
        if (if0.underflow !== 1'b1) $display("FAIL pre_reset_underflow got %b want 1", if0.underflow);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) cyc0(1'b1, 8'(i), 1'b0);
        total_cnt++;
        if (if0.count !== 5'd5) $display("FAIL pre_reset_count got %0d want 5", if0.count);
        else pass_cnt++;
        // Assert reset between edges and check before the next edge.
        #1 rst = 1'b1;
        #1;
        total_cnt++;
        if (if0.count !== 5'd0) $display("FAIL reset_count got %0d want 0", if0.count);
        else pass_cnt++;
        total_cnt++;
        if ({if0.rempty, if0.ralmost_empty, if0.wfull, if0.walmost_full} !== 4'b1100)
            $display("FAIL reset_flags got %b want 1100",
                     {if0.rempty, if0.ralmost_empty, if0.wfull, if0.walmost_full});
        else pass_cnt++;
        total_cnt++;
        if ({if0.overflow, if0.underflow} !== 2'b00)
            $display("FAIL reset_errs got %b want 00", {if0.overflow, if0.underflow});
        else pass_cnt++;
        total_cnt++;
        if (if0.rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", if0.rdata);
        else pass_cnt++;
        #1 rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        logic e;
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b1, 8'(i), 1'b0);
            total_cnt++;
            if (if0.count !== 5'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, if0.count, i + 1);
            else pass_cnt++;
            e = (i + 1 >= 14);
            total_cnt++;
            if (if0.walmost_full !== e) $display("FAIL fill_afull[%0d] got %b want %b", i, if0.walmost_full, e);
            else pass_cnt++;
            e = (i + 1 == 16);
            total_cnt++;
            if (if0.wfull !== e) $display("FAIL fill_full[%0d] got %b want %b", i, if0.wfull, e);
            else pass_cnt++;
        end
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b0, 8'h00, 1'b1);
            total_cnt++;
            if (if0.rdata !== 8'(i)) $display("FAIL drain_rdata[%0d] got %h want %h", i, if0.rdata, 8'(i));
            else pass_cnt++;
            e = (15 - i <= 2);
            total_cnt++;
            if (if0.ralmost_empty !== e) $display("FAIL drain_aempty[%0d] got %b want %b", i, if0.ralmost_empty, e);
            else pass_cnt++;
        end
        total_cnt++;
        if (if0.rempty !== 1'b1) $display("FAIL drain_empty got %b want 1", if0.rempty);
        else pass_cnt++;
        cyc0(1'b0, 8'h00, 1'b0);
        total_cnt++;
        if (if0.rdata !== 8'h0F) $display("FAIL rdata_hold got %h want 0f", if0.rdata);
        else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        for (int i = 0; i < 16; i++) cyc0(1'b1, 8'h30 + 8'(i), 1'b0);
        cyc0(1'b1, 8'hAA, 1'b1);
        total_cnt++;
        if (if0.count !== 5'd15) $display("FAIL ovf_count got %0d want 15", if0.count);
        else pass_cnt++;
        total_cnt++;
        if (if0.overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", if0.overflow);
        else pass_cnt++;
        total_cnt++;
        if (if0.rdata !== 8'h30) $display("FAIL ovf_rdata got %h want 30", if0.rdata);
        else pass_cnt++;
        cyc0(1'b1, 8'hBB, 1'b0);
        total_cnt++;
        if ({if0.count, if0.wfull, if0.overflow} !== {5'd16, 1'b1, 1'b1})
            $display("FAIL ovf_refill got count=%0d full=%b ovf=%b want 16 1 1",
                     if0.count, if0.wfull, if0.overflow);
        else pass_cnt++;
        for (int i = 1; i < 16; i++) exp_q.push_back(8'h30 + 8'(i));
        exp_q.push_back(8'hBB);
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b0, 8'h00, 1'b1);
            total_cnt++;
            if (if0.rdata !== exp_q[i]) $display("FAIL ovf_drain[%0d] got %h want %h", i, if0.rdata, exp_q[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_underflow();
        pulse_reset();
        cyc0(1'b1, 8'h55, 1'b1);
        total_cnt++;
        if ({if0.underflow, if0.count, if0.rempty} !== {1'b1, 5'd1, 1'b0})
            $display("FAIL unf_state got unf=%b count=%0d empty=%b want 1 1 0",
                     if0.underflow, if0.count, if0.rempty);
        else pass_cnt++;
        cyc0(1'b0, 8'h00, 1'b1);
        total_cnt++;
        if (if0.rdata !== 8'h55) $display("FAIL unf_rdata got %h want 55", if0.rdata);
        else pass_cnt++;
        total_cnt++;
        if (if0.rempty !== 1'b1) $display("FAIL unf_empty got %b want 1", if0.rempty);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) cyc0(1'b1, 8'h60 + 8'(i), 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc0(1'b1, 8'h63 + 8'(i), 1'b1);
            total_cnt++;
            if (if0.rdata !== 8'h60 + 8'(i))
                $display("FAIL wrap_rdata[%0d] got %h want %h", i, if0.rdata, 8'h60 + 8'(i));
            else pass_cnt++;
            total_cnt++;
            if ({if0.count, if0.wfull, if0.rempty} !== {5'd3, 2'b00})
                $display("FAIL wrap_state[%0d] got count=%0d full=%b empty=%b want 3 0 0",
                         i, if0.count, if0.wfull, if0.rempty);
            else pass_cnt++;
        end
    endtask

    task automatic test_fwft();
        pulse_reset();
        total_cnt++;
        if ({if1.rempty, if1.rdata} !== {1'b1, 8'h00})
            $display("FAIL fwft_reset got empty=%b rdata=%h want 1 00", if1.rempty, if1.rdata);
        else pass_cnt++;
        cyc1(1'b1, 8'h11, 1'b0);
        total_cnt++;
        if ({if1.rempty, if1.rdata} !== {1'b0, 8'h11})
            $display("FAIL fwft_first got empty=%b rdata=%h want 0 11", if1.rempty, if1.rdata);
        else pass_cnt++;
        cyc1(1'b1, 8'h22, 1'b0);
        total_cnt++;
        if (if1.rdata !== 8'h11) $display("FAIL fwft_hold got %h want 11", if1.rdata);
        else pass_cnt++;
        cyc1(1'b0, 8'h00, 1'b1);
        total_cnt++;
        if ({if1.count, if1.rdata} !== {5'd1, 8'h22})
            $display("FAIL fwft_pop got count=%0d rdata=%h want 1 22", if1.count, if1.rdata);
        else pass_cnt++;
        cyc1(1'b0, 8'h00, 1'b1);
        total_cnt++;
        if (if1.rempty !== 1'b1) $display("FAIL fwft_empty got %b want 1", if1.rempty);
        else pass_cnt++;
    endtask

    initial begin
        if0.winc = 1'b0; if0.rinc = 1'b0; if0.wdata = '0;
        if1.winc = 1'b0; if1.rinc = 1'b0; if1.wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_fwft();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
